uart_fifo_core: RTL and testbench

//  Single-clock UART transceiver: parametrised TX/RX serialisers plus internal baud-tick generator and TX/RX FIFOs.

---
 rtl/uart_fifo_core_if.sv | 23 ++
 rtl/uart_fifo_core.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_uart_fifo_core.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_fifo_core_if.sv
// Host-side handshake bundle for uart_fifo_core: TX FIFO write port and RX FIFO read port.
interface uart_fifo_core_if #(
  parameter int unsigned DATA_LENGTH = 8
);
  logic [DATA_LENGTH-1:0] TX_P_DATA_IN;
  logic                   TX_VALID;
  logic                   TX_READY;
  logic [DATA_LENGTH-1:0] RX_P_DATA_OUT;
  logic                   RX_VALID;
  logic                   RX_READY;
  logic                   Parity_Error;
  logic                   Stop_Error;

  modport master (
    output TX_P_DATA_IN, TX_VALID, RX_READY,
    input  TX_READY, RX_P_DATA_OUT, RX_VALID, Parity_Error, Stop_Error
  );

  modport slave (
    input  TX_P_DATA_IN, TX_VALID, RX_READY,
    output TX_READY, RX_P_DATA_OUT, RX_VALID, Parity_Error, Stop_Error
  );
endinterface

// File: rtl/uart_fifo_core.sv
// Single-clock UART with baud-tick generator, TX/RX FIFOs and per-frame error tagging.
// Optional feature macro: UART_LOOPBACK_EN (adds LOOPBACK input, RX fed from internal TX serial).
module uart_fifo_core #(
  parameter int unsigned DATA_LENGTH = 8,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned DIV_WIDTH   = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [DIV_WIDTH-1:0] BAUD_DIV,
  input  logic                 PAR_EN,
  input  logic                 PAR_TYP,
  input  logic                 STOP2,
  output logic                 TX_OUT,
  output logic                 Busy,
  input  logic                 RX_IN,
`ifdef UART_LOOPBACK_EN
  input  logic                 LOOPBACK,
`endif
  output logic                 RX_OVERRUN,
  uart_fifo_core_if.slave      host
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned BW = $clog2(DATA_LENGTH);
  localparam int unsigned RW = DATA_LENGTH + 2;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  // Oversample tick: free-running 0..BAUD_DIV
  logic [DIV_WIDTH-1:0] div_cnt;
  logic                 tick;
  assign tick = (div_cnt >= BAUD_DIV);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)      div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DIV_WIDTH'(1);
  end

  // TX FIFO
  logic [DATA_LENGTH-1:0] tx_mem [FIFO_DEPTH];
  logic [AW:0]            tx_wr, tx_rd;
  logic                   tx_full, tx_empty, tx_push, tx_pop;
  assign tx_full       = (tx_wr[AW] != tx_rd[AW]) && (tx_wr[AW-1:0] == tx_rd[AW-1:0]);
  assign tx_empty      = (tx_wr == tx_rd);
  assign tx_push       = host.TX_VALID & ~tx_full;
  assign host.TX_READY = ~tx_full;

  always_ff @(posedge CLK) begin
    if (tx_push) tx_mem[tx_wr[AW-1:0]] <= host.TX_P_DATA_IN;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tx_wr <= '0;
      tx_rd <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + (AW+1)'(1);
      if (tx_pop)  tx_rd <= tx_rd + (AW+1)'(1);
    end
  end

  // TX serialiser
  tx_state_t              tx_state, tx_state_n;
  logic [4:0]             tx_cnt, tx_cnt_n;
  logic [BW-1:0]          tx_bit, tx_bit_n;
  logic [DATA_LENGTH-1:0] tx_shift, tx_shift_n, tx_head;
  logic                   tx_par_en, tx_par_en_n, tx_par_bit, tx_par_bit_n;
  logic                   tx_stop2, tx_stop2_n, tx_q, tx_q_n, tx_load;
  assign tx_head = tx_mem[tx_rd[AW-1:0]];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tx_state   <= TX_IDLE;
      tx_cnt     <= '0;
      tx_bit     <= '0;
      tx_shift   <= '0;
      tx_par_en  <= 1'b0;
      tx_par_bit <= 1'b0;
      tx_stop2   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_state   <= tx_state_n;
      tx_cnt     <= tx_cnt_n;
      tx_bit     <= tx_bit_n;
      tx_shift   <= tx_shift_n;
      tx_par_en  <= tx_par_en_n;
      tx_par_bit <= tx_par_bit_n;
      tx_stop2   <= tx_stop2_n;
      tx_q       <= tx_q_n;
    end
  end

  always_comb begin
    tx_state_n   = tx_state;
    tx_cnt_n     = tx_cnt;
    tx_bit_n     = tx_bit;
    tx_shift_n   = tx_shift;
    tx_par_en_n  = tx_par_en;
    tx_par_bit_n = tx_par_bit;
    tx_stop2_n   = tx_stop2;
    tx_q_n       = tx_q;
    tx_load      = 1'b0;
    tx_pop       = 1'b0;
    if (tick) begin
      unique case (tx_state)
        TX_IDLE: tx_load = ~tx_empty;
        TX_START: begin
          if (tx_cnt == 5'd15) begin
            tx_state_n = TX_DATA;
            tx_cnt_n   = '0;
            tx_bit_n   = '0;
            tx_q_n     = tx_shift[0];
          end else tx_cnt_n = tx_cnt + 5'd1;
        end
        TX_DATA: begin
          if (tx_cnt == 5'd15) begin
            tx_cnt_n = '0;
            if (tx_bit == BW'(DATA_LENGTH - 1)) begin
              tx_state_n = tx_par_en ? TX_PARITY : TX_STOP;
              tx_q_n     = tx_par_en ? tx_par_bit : 1'b1;
            end else begin
              tx_bit_n   = tx_bit + BW'(1);
              tx_shift_n = {1'b0, tx_shift[DATA_LENGTH-1:1]};
              tx_q_n     = tx_shift[1];
            end
          end else tx_cnt_n = tx_cnt + 5'd1;
        end
        TX_PARITY: begin
          if (tx_cnt == 5'd15) begin
            tx_state_n = TX_STOP;
            tx_cnt_n   = '0;
            tx_q_n     = 1'b1;
          end else tx_cnt_n = tx_cnt + 5'd1;
        end
        TX_STOP: begin
          // Last stop tick chains straight into the next queued frame
          if (tx_cnt == (tx_stop2 ? 5'd31 : 5'd15)) begin
            tx_cnt_n   = '0;
            tx_state_n = TX_IDLE;
            tx_load    = ~tx_empty;
          end else tx_cnt_n = tx_cnt + 5'd1;
        end
        default: tx_state_n = TX_IDLE;
      endcase
    end
    if (tx_load) begin
      tx_pop       = 1'b1;
      tx_state_n   = TX_START;
      tx_cnt_n     = '0;
      tx_shift_n   = tx_head;
      tx_par_en_n  = PAR_EN;
      tx_par_bit_n = (^tx_head) ^ PAR_TYP;
      tx_stop2_n   = STOP2;
      tx_q_n       = 1'b0;
    end
  end

  assign Busy = ~tx_empty | (tx_state != TX_IDLE);

  logic rx_src;
`ifdef UART_LOOPBACK_EN
  assign rx_src = LOOPBACK ? tx_q : RX_IN;
  assign TX_OUT = LOOPBACK | tx_q;
`else
  assign rx_src = RX_IN;
  assign TX_OUT = tx_q;
`endif

  // RX synchroniser and deserialiser
  logic                   rx_s1, rx_s2;
  rx_state_t              rx_state, rx_state_n;
  logic [3:0]             rx_cnt, rx_cnt_n;
  logic [BW-1:0]          rx_bit, rx_bit_n;
  logic [DATA_LENGTH-1:0] rx_shift, rx_shift_n;
  logic                   rx_par_err, rx_par_err_n, rx_push;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      rx_par_err <= 1'b0;
    end else begin
      rx_s1      <= rx_src;
      rx_s2      <= rx_s1;
      rx_state   <= rx_state_n;
      rx_cnt     <= rx_cnt_n;
      rx_bit     <= rx_bit_n;
      rx_shift   <= rx_shift_n;
      rx_par_err <= rx_par_err_n;
    end
  end

  always_comb begin
    rx_state_n   = rx_state;
    rx_cnt_n     = rx_cnt;
    rx_bit_n     = rx_bit;
    rx_shift_n   = rx_shift;
    rx_par_err_n = rx_par_err;
    rx_push      = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        if (!rx_s2) begin
          rx_state_n   = RX_START;
          rx_cnt_n     = '0;
          rx_par_err_n = 1'b0;
        end
      end
      RX_START: begin
        if (tick) begin
          if (rx_cnt == 4'd7) begin
            rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
            rx_cnt_n   = '0;
            rx_bit_n   = '0;
          end else rx_cnt_n = rx_cnt + 4'd1;
        end
      end
      RX_DATA: begin
        if (tick) begin
          if (rx_cnt == 4'd15) begin
            rx_cnt_n   = '0;
            rx_shift_n = {rx_s2, rx_shift[DATA_LENGTH-1:1]};
            if (rx_bit == BW'(DATA_LENGTH - 1)) rx_state_n = PAR_EN ? RX_PARITY : RX_STOP;
            else                                rx_bit_n   = rx_bit + BW'(1);
          end else rx_cnt_n = rx_cnt + 4'd1;
        end
      end
      RX_PARITY: begin
        if (tick) begin
          if (rx_cnt == 4'd15) begin
            rx_cnt_n     = '0;
            rx_par_err_n = rx_s2 ^ (^rx_shift) ^ PAR_TYP;
            rx_state_n   = RX_STOP;
          end else rx_cnt_n = rx_cnt + 4'd1;
        end
      end
      RX_STOP: begin
        // Centre of first stop bit: hand frame to FIFO and rearm for the next start edge
        if (tick) begin
          if (rx_cnt == 4'd15) begin
            rx_push    = 1'b1;
            rx_cnt_n   = '0;
            rx_state_n = RX_IDLE;
          end else rx_cnt_n = rx_cnt + 4'd1;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // RX FIFO: full decision uses pre-pop pointers, so push+pop while full overruns
  logic [RW-1:0] rx_mem [FIFO_DEPTH];
  logic [RW-1:0] rx_head;
  logic [AW:0]   rx_wr, rx_rd;
  logic          rx_full, rx_empty, rx_wr_en, rx_pop;
  assign rx_full  = (rx_wr[AW] != rx_rd[AW]) && (rx_wr[AW-1:0] == rx_rd[AW-1:0]);
  assign rx_empty = (rx_wr == rx_rd);
  assign rx_wr_en = rx_push & ~rx_full;
  assign rx_pop   = ~rx_empty & host.RX_READY;

  always_ff @(posedge CLK) begin
    if (rx_wr_en) rx_mem[rx_wr[AW-1:0]] <= {~rx_s2, rx_par_err, rx_shift};
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_wr      <= '0;
      rx_rd      <= '0;
      RX_OVERRUN <= 1'b0;
    end else begin
      if (rx_wr_en) rx_wr <= rx_wr + (AW+1)'(1);
      if (rx_pop)   rx_rd <= rx_rd + (AW+1)'(1);
      RX_OVERRUN <= rx_push & rx_full;
    end
  end

  assign rx_head           = rx_empty ? '0 : rx_mem[rx_rd[AW-1:0]];
  assign host.RX_VALID      = ~rx_empty;
  assign host.RX_P_DATA_OUT = rx_head[DATA_LENGTH-1:0];
  assign host.Parity_Error  = rx_head[DATA_LENGTH];
  assign host.Stop_Error    = rx_head[DATA_LENGTH+1];
endmodule

// File: tb/tb_uart_fifo_core.sv
// Scoreboard bench for uart_fifo_core: TX serial monitor and RX FIFO monitor check queued expectations.
module tb_uart_fifo_core;
  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] BAUD_DIV;
  logic        PAR_EN, PAR_TYP, STOP2, RX_IN;
  logic        TX_OUT, Busy, RX_OVERRUN;
`ifdef UART_LOOPBACK_EN
  logic        LOOPBACK = 1'b0;
`endif

  uart_fifo_core_if #(.DATA_LENGTH(8)) host_if ();

  uart_fifo_core #(.DATA_LENGTH(8), .FIFO_DEPTH(8), .DIV_WIDTH(16)) dut (
    .CLK(CLK), .RST(RST), .BAUD_DIV(BAUD_DIV), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .STOP2(STOP2), .TX_OUT(TX_OUT), .Busy(Busy), .RX_IN(RX_IN),
`ifdef UART_LOOPBACK_EN
    .LOOPBACK(LOOPBACK),
`endif
    .RX_OVERRUN(RX_OVERRUN), .host(host_if)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] data;
    bit         par_en;
    bit         par_bit;
    bit         stop2;
    bit         b2b;
  } tx_exp_t;

  tx_exp_t    txq[$];
  logic [9:0] rxq[$];
  int checks = 0;
  int errors = 0;
  int tx_started = 0;
  int tx_done = 0;
  int ovr_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic write_tx(input logic [7:0] d, input bit b2b);
    txq.push_back('{data: d, par_en: PAR_EN, par_bit: 1'b0, stop2: STOP2, b2b: b2b});
    host_if.TX_P_DATA_IN = d;
    host_if.TX_VALID     = 1'b1;
    tick();
    host_if.TX_VALID     = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] d, input bit par_bit, input bit stop_bit);
    RX_IN = 1'b0;
    repeat (16) tick();
    for (int i = 0; i < 8; i++) begin
      RX_IN = d[i];
      repeat (16) tick();
    end
    if (PAR_EN) begin
      RX_IN = par_bit;
      repeat (16) tick();
    end
    RX_IN = stop_bit;
    repeat (16) tick();
    RX_IN = 1'b1;
    repeat (24) tick();
  endtask

  task automatic wait_tx_done(input int target);
    int n = 0;
    while (tx_done < target && n < 3000) begin
      tick();
      n++;
    end
    check("tx_done_timeout", 32'(tx_done >= target), 32'd1);
  endtask

  // TX monitor: every frame must match its queued expectation clock-for-clock
  initial begin : tx_mon
    tx_exp_t     e;
    logic [11:0] fb;
    int          nb, bad;
    bit          aborted, skip;
    skip = 1'b0;
    forever begin
      if (!skip) @(negedge CLK);
      skip = 1'b0;
      if (RST === 1'b1 && TX_OUT === 1'b0) begin
        if (txq.size() == 0) begin
          check("tx_unexpected_frame", 32'(TX_OUT), 32'd1);
          repeat (16) @(negedge CLK);
        end else begin
          e = txq.pop_front();
          tx_started++;
          fb = '1;
          fb[0] = 1'b0;
          for (int i = 0; i < 8; i++) fb[i+1] = e.data[i];
          nb = 9;
          if (e.par_en) begin
            fb[nb] = e.par_bit;
            nb++;
          end
          nb += e.stop2 ? 2 : 1;
          aborted = 1'b0;
          for (int b = 0; b < nb && !aborted; b++) begin
            bad = 0;
            for (int c = 0; c < 16; c++) begin
              if (b != 0 || c != 0) @(negedge CLK);
              if (RST !== 1'b1) begin
                aborted = 1'b1;
                break;
              end
              if (TX_OUT !== fb[b]) bad++;
            end
            if (!aborted) check($sformatf("tx_%02h_bit%0d_badclks", e.data, b), 32'(bad), 32'd0);
          end
          if (!aborted) begin
            tx_done++;
            if (txq.size() > 0 && txq[0].b2b) begin
              @(negedge CLK);
              check("tx_b2b_gap", 32'(TX_OUT), 32'd0);
              skip = 1'b1;
            end
          end
        end
      end
    end
  end

  // RX monitor: every completed pop must match the head of the expected queue
  initial begin : rx_mon
    logic [9:0] exp;
    forever begin
      @(negedge CLK);
      if (RX_OVERRUN === 1'b1) ovr_cnt++;
      if (host_if.RX_VALID === 1'b1 && host_if.RX_READY === 1'b1) begin
        if (rxq.size() == 0) begin
          check("rx_unexpected_entry", 32'(host_if.RX_VALID), 32'd0);
        end else begin
          exp = rxq.pop_front();
          check("rx_entry", 32'({host_if.Stop_Error, host_if.Parity_Error, host_if.RX_P_DATA_OUT}),
                32'(exp));
        end
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin : stim
    RST = 1'b0;
    BAUD_DIV = 16'd0;
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;
    STOP2 = 1'b0;
    RX_IN = 1'b1;
    host_if.TX_P_DATA_IN = '0;
    host_if.TX_VALID = 1'b0;
    host_if.RX_READY = 1'b1;
    repeat (3) tick();
    check("rst_tx_out",   32'(TX_OUT), 32'd1);
    check("rst_busy",     32'(Busy), 32'd0);
    check("rst_tx_ready", 32'(host_if.TX_READY), 32'd1);
    check("rst_rx_valid", 32'(host_if.RX_VALID), 32'd0);
    check("rst_rx_data",  32'(host_if.RX_P_DATA_OUT), 32'd0);
    check("rst_par_err",  32'(host_if.Parity_Error), 32'd0);
    check("rst_stop_err", 32'(host_if.Stop_Error), 32'd0);
    check("rst_overrun",  32'(RX_OVERRUN), 32'd0);
    RST = 1'b1;
    repeat (2) tick();

    // TX 0xA5, no parity, one stop bit
    write_tx(8'hA5, 1'b0);
    repeat (40) tick();
    check("busy_mid_frame", 32'(Busy), 32'd1);
    wait_tx_done(1);
    @(negedge CLK);
    check("busy_after_stop", 32'(Busy), 32'd0);

    // TX 0x3C with odd parity: 4 ones -> parity bit 1
    PAR_EN = 1'b1;
    PAR_TYP = 1'b1;
    tick();
    write_tx(8'h3C, 1'b0);
    txq[txq.size()-1].par_bit = 1'b1;
    wait_tx_done(2);

    // RX with even parity
    PAR_TYP = 1'b0;
    rxq.push_back(10'h13C);
    send_rx(8'h3C, 1'b1, 1'b1);
    rxq.push_back(10'h03C);
    send_rx(8'h3C, 1'b0, 1'b1);
    // RX with odd parity: 0x07 has 3 ones -> parity bit 0
    PAR_TYP = 1'b1;
    rxq.push_back(10'h007);
    send_rx(8'h07, 1'b0, 1'b1);
    rxq.push_back(10'h107);
    send_rx(8'h07, 1'b1, 1'b1);

    // Stop error, then clean frame
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;
    rxq.push_back(10'h255);
    send_rx(8'h55, 1'b0, 1'b0);
    rxq.push_back(10'h012);
    send_rx(8'h12, 1'b0, 1'b1);
    check("rx_queue_drained_a", 32'(rxq.size()), 32'd0);

    // False start: 5 low ticks
    RX_IN = 1'b0;
    repeat (5) tick();
    RX_IN = 1'b1;
    repeat (40) tick();
    check("false_start_no_valid", 32'(host_if.RX_VALID), 32'd0);

    // Overrun: 9 frames into an 8-deep FIFO with no pops
    host_if.RX_READY = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      rxq.push_back(10'(i));
      send_rx(8'(i), 1'b0, 1'b1);
    end
    check("no_overrun_at_8", 32'(ovr_cnt), 32'd0);
    check("tx_ready_unaffected", 32'(host_if.TX_READY), 32'd1);
    send_rx(8'h09, 1'b0, 1'b1);
    check("overrun_once_at_9", 32'(ovr_cnt), 32'd1);
    host_if.RX_READY = 1'b1;
    repeat (20) tick();
    check("rx_queue_drained_b", 32'(rxq.size()), 32'd0);
    check("rx_valid_after_drain", 32'(host_if.RX_VALID), 32'd0);

    // Two stop bits, back-to-back frames, reset during second frame data
    STOP2 = 1'b1;
    tick();
    host_if.TX_P_DATA_IN = 8'hFF;
    host_if.TX_VALID = 1'b1;
    txq.push_back('{data: 8'hFF, par_en: 1'b0, par_bit: 1'b0, stop2: 1'b1, b2b: 1'b0});
    tick();
    host_if.TX_P_DATA_IN = 8'h00;
    txq.push_back('{data: 8'h00, par_en: 1'b0, par_bit: 1'b0, stop2: 1'b1, b2b: 1'b1});
    tick();
    host_if.TX_VALID = 1'b0;
    begin
      int n = 0;
      while (tx_started < 4 && n < 3000) begin
        tick();
        n++;
      end
      check("second_frame_start_timeout", 32'(tx_started >= 4), 32'd1);
    end
    repeat (40) tick();
    RST = 1'b0;
    #1;
    check("rst_async_tx_out", 32'(TX_OUT), 32'd1);
    check("rst_async_tx_ready", 32'(host_if.TX_READY), 32'd1);
    check("rst_async_busy", 32'(Busy), 32'd0);
    repeat (3) tick();
    RST = 1'b1;
    repeat (300) tick();
    check("no_tx_after_reset", 32'(TX_OUT), 32'd1);
    check("busy_after_reset", 32'(Busy), 32'd0);
    check("tx_queue_drained", 32'(txq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
